// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, idle line level
// and the parity helpers used by the transmit and receive paths.
package uart_pkg;

  localparam int   UART_DATA_W     = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Fold one more data bit into a running XOR parity accumulator.
  function automatic logic uart_par_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

  // Turn the XOR of all data bits into the parity bit placed on the line.
  function automatic logic uart_par_final(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous show-ahead FIFO. Full/empty come from the occupancy
// counter only; pointers are free-running and wrap because DEPTH is 2^n.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [W-1:0]           din,
  input  logic                   rd_en,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == (AW+1)'(0));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes are queued in a FIFO and serialised as
// start, 8 data bits LSB first, optional parity and 1-2 stop bits, one bit
// per baud_tick.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   baud_tick,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam logic PAR_EN    = (PARITY_EN != 0);
  localparam logic PAR_ODD   = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   pop_s;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   fifo_full, fifo_empty;

  // in_ready depends only on the registered occupancy, so a pop in the same
  // cycle never lets a push into a full FIFO.
  assign in_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = busy_q;

  uart_sync_fifo #(
    .W     (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (in_valid && in_ready),
    .din   (in_data),
    .rd_en (pop_s),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencing: everything advances only on baud ticks.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    pop_s      = 1'b0;
    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop_s   = 1'b1;
            shift_d = fifo_dout;
            tx_d    = 1'b0;
            par_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_START;
          end else begin
            tx_d   = UART_IDLE_LEVEL;
            busy_d = 1'b0;
          end
        end
        ST_START: begin
          tx_d      = shift_q[0];
          par_d     = uart_par_step(par_q, shift_q[0]);
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[UART_DATA_W-1:1]};
            tx_d      = shift_q[1];
            par_d     = uart_par_step(par_q, shift_q[1]);
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (PAR_EN) begin
            tx_d    = uart_par_final(par_q, PAR_ODD);
            state_d = ST_PARITY;
          end else begin
            tx_d       = UART_IDLE_LEVEL;
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
          end
        end
        ST_PARITY: begin
          tx_d       = UART_IDLE_LEVEL;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          tx_d = UART_IDLE_LEVEL;
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          tx_d    = UART_IDLE_LEVEL;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Transmit state and registered line/busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame tables, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_tx_buffered;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          baud_tick;
  logic [7:0]    in_data;
  logic          in_valid, in_valid_o, in_valid_s;
  logic          in_ready, tx, busy;
  logic [CW-1:0] fifo_count;
  logic          in_ready_o, tx_o, busy_o;
  logic [CW-1:0] fifo_count_o;
  logic          in_ready_s, tx_s, busy_s;
  logic [CW-1:0] fifo_count_s;

  always #5 clk = ~clk;

  uart_tx_buffered #(.DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .tx(tx), .busy(busy),
    .fifo_count(fifo_count));

  uart_tx_buffered #(.DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(in_valid_o), .in_ready(in_ready_o), .tx(tx_o), .busy(busy_o),
    .fifo_count(fifo_count_o));

  uart_tx_buffered #(.DEPTH(DEPTH), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_s2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .tx(tx_s), .busy(busy_s),
    .fifo_count(fifo_count_s));

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // bit0 = start, [8:1] = data LSB first, [9] = parity/stop, [10] = stop
  } vec_t;

  vec_t   tbl [6];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     tick_mode = 0;   // 0 none, 1 every 16 clks, 2 constant, 3 random
  int     tick_phase = 0;
  longint cyc = 0;

  // Reference model of the default instance (even parity, 1 stop bit).
  logic [7:0] m_q [$];
  logic       m_rem [$];
  logic       m_line = 1'b1;
  logic       m_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rem.delete();
    m_line = 1'b1;
    m_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] d;
    bit         full;
    if (reset) begin
      model_reset();
    end else begin
      full = (m_q.size() >= DEPTH);
      if (baud_tick) begin
        if (!m_busy) begin
          if (m_q.size() > 0) begin
            d = m_q.pop_front();
            m_rem.delete();
            for (int i = 0; i < 8; i++) m_rem.push_back(d[i]);
            m_rem.push_back(logic'($countones(d) % 2));
            m_rem.push_back(1'b1);
            m_line = 1'b0;
            m_busy = 1'b1;
          end
        end else if (m_rem.size() > 0) begin
          m_line = m_rem.pop_front();
        end else begin
          m_busy = 1'b0;
        end
      end
      if (in_valid && !full) m_q.push_back(in_data);
    end
  endtask

  function automatic logic sel_tx(input int w);
    case (w)
      0:       return tx;
      1:       return tx_o;
      default: return tx_s;
    endcase
  endfunction

  function automatic logic sel_busy(input int w);
    case (w)
      0:       return busy;
      1:       return busy_o;
      default: return busy_s;
    endcase
  endfunction

  function automatic logic [CW-1:0] sel_count(input int w);
    case (w)
      0:       return fifo_count;
      1:       return fifo_count_o;
      default: return fifo_count_s;
    endcase
  endfunction

  // One clock: choose the tick, advance the model, then compare at negedge.
  task automatic cycle();
    case (tick_mode)
      0: baud_tick = 1'b0;
      1: begin
        baud_tick  = (tick_phase == 15);
        tick_phase = (tick_phase + 1) % 16;
      end
      2: baud_tick = 1'b1;
      default: baud_tick = ($urandom_range(0, 3) == 0);
    endcase
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("tx", tx, m_line);
    check("busy", busy, m_busy);
    check("in_ready", in_ready, m_q.size() < DEPTH);
    check("fifo_count", fifo_count, m_q.size());
  endtask

  // Push one byte into instance w and check its frame bit by bit mid-period.
  task automatic run_frame(input int w, input logic [7:0] d, input logic [10:0] exp, input string name);
    bit started = 1'b0;
    in_data = d;
    in_valid = (w == 0); in_valid_o = (w == 1); in_valid_s = (w == 2);
    cycle();
    in_valid = 1'b0; in_valid_o = 1'b0; in_valid_s = 1'b0;
    check({name, " count after push"}, sel_count(w), 1);
    for (int i = 0; i < 64 && !started; i++) begin
      cycle();
      if (sel_tx(w) == 1'b0) started = 1'b1;
    end
    check({name, " start seen"}, started, 1'b1);
    check({name, " count at start"}, sel_count(w), 0);
    for (int k = 0; k < 11; k++) begin
      repeat (8) cycle();
      check($sformatf("%s bit%0d", name, k), sel_tx(w), exp[k]);
      check($sformatf("%s busy%0d", name, k), sel_busy(w), 1'b1);
      repeat (8) cycle();
    end
    repeat (8) cycle();
    check({name, " idle tx"}, sel_tx(w), 1'b1);
    check({name, " idle busy"}, sel_busy(w), 1'b0);
  endtask

  initial begin
    longint starts [$];
    logic   prev;
    logic [10:0] f81;

    tbl[0] = '{8'hA5, 11'b1_0_10100101_0};
    tbl[1] = '{8'h00, 11'b1_0_00000000_0};
    tbl[2] = '{8'hFF, 11'b1_0_11111111_0};
    tbl[3] = '{8'h01, 11'b1_1_00000001_0};
    tbl[4] = '{8'h80, 11'b1_1_10000000_0};
    tbl[5] = '{8'h07, 11'b1_1_00000111_0};
    f81 = 11'b1_0_10000001_0;

    reset = 1'b1; baud_tick = 1'b0; in_data = 8'h00;
    in_valid = 1'b0; in_valid_o = 1'b0; in_valid_s = 1'b0;
    repeat (2) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset count", fifo_count, 0);
    check("reset in_ready", in_ready, 1'b1);
    check("reset in_ready odd", in_ready_o, 1'b1);
    check("reset in_ready s2", in_ready_s, 1'b1);
    reset = 1'b0;

    // Frame table on the default instance, tick every 16 clks.
    tick_mode = 1; tick_phase = 0;
    for (int i = 0; i < 6; i++) run_frame(0, tbl[i].data, tbl[i].frame, $sformatf("tbl%0d", i));

    // Odd parity and two-stop/no-parity instances.
    run_frame(1, 8'h00, 11'b1_1_00000000_0, "odd00");
    run_frame(2, 8'h3C, 11'b1_1_00111100_0, "stop2");

    // Fill the FIFO with no ticks, then drain back to back.
    tick_mode = 0;
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'(i);
      cycle();
      if (i == 4) check("ready after 4th", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    check("count after 5 pushes", fifo_count, 4);
    tick_mode = 1; tick_phase = 0;
    prev = busy;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (busy && !prev) starts.push_back(cyc);
      prev = busy;
    end
    check("frames sent", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++)
      check("frame spacing", 32'(starts[i] - starts[i-1]), 192);
    check("drained count", fifo_count, 0);

    // Constant baud_tick: one bit per clock.
    tick_mode = 2;
    in_data = 8'h81; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("fast start tx", tx, 1'b0);
    check("fast start busy", busy, 1'b1);
    for (int k = 1; k < 11; k++) begin
      cycle();
      check($sformatf("fast bit%0d", k), tx, f81[k]);
    end
    cycle();
    check("fast done busy", busy, 1'b0);
    check("fast done tx", tx, 1'b1);

    // Randomized traffic and ticks, then drain.
    tick_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    tick_mode = 1; tick_phase = 0;
    repeat (1200) cycle();

    // Reset in the middle of data bit 3 of 8'hFF with two bytes queued.
    tick_mode = 0;
    in_valid = 1'b1;
    in_data = 8'hFF; cycle();
    in_data = 8'h01; cycle();
    in_data = 8'h02; cycle();
    in_valid = 1'b0;
    tick_mode = 1; tick_phase = 0;
    for (int i = 0; i < 40 && !m_busy; i++) cycle();
    check("abort frame started", m_busy, 1'b1);
    repeat (4 * 16 + 8) cycle();
    check("pre-reset bit3", tx, 1'b1);
    check("pre-reset count", fifo_count, 2);
    reset = 1'b1;
    #1;
    check("async reset tx", tx, 1'b1);
    check("async reset busy", busy, 1'b0);
    check("async reset count", fifo_count, 0);
    check("async reset in_ready", in_ready, 1'b1);
    model_reset();
    cycle();
    reset = 1'b0;
    repeat (400) cycle();
    check("post-reset busy", busy, 1'b0);
    check("post-reset tx", tx, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
